dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port 1 KB data memory. Shares the memory between the core's MEM-stage request port (port 0) and a DMA/debug request port (port 1). Uses valid/ready request handshakes, a registered command stage and a fixed two-cycle response latency. Sits between the pipeline/DMA engine and the data memory's `mem_read`/`mem_write`/`alu_result`/`write_data`/`read_data` pins.

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and command sequencer for the single-port data memory.
// DMEM_ARB_RR_EN selects strict round-robin; otherwise fixed priority with a MAX_WAIT starvation override.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic        req0_we_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  output logic        resp0_valid_o,
  output logic [31:0] resp0_rdata_o,
  output logic        resp0_err_o,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic        req1_we_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        resp1_valid_o,
  output logic [31:0] resp1_rdata_o,
  output logic        resp1_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  logic gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On conflict the port that did not win last time gets the slot.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid_i && req1_valid_i) begin
        gnt0 = last_grant_q;
        gnt1 = !last_grant_q;
      end else begin
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0)      last_grant_d = 1'b0;
    else if (gnt1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       starve;

  assign starve = (wait_cnt_q == 4'(MAX_WAIT));
  assign gnt1   = !rst && req1_valid_i && (!req0_valid_i || starve);
  assign gnt0   = !rst && req0_valid_i && !gnt1;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt1)                         wait_cnt_d = 4'd0;
    else if (req1_valid_i && !starve) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= 4'd0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // Command stage: holds the accepted request during its memory access cycle.
  logic        cmd_valid_q, cmd_port_q, cmd_we_q, cmd_err_q;
  logic [31:0] cmd_addr_q, cmd_wdata_q;
  logic        cmd_valid_d, cmd_port_d, cmd_we_d, cmd_err_d;
  logic [31:0] cmd_addr_d, cmd_wdata_d;

  always_comb begin
    cmd_valid_d = gnt0 || gnt1;
    cmd_port_d  = gnt1;
    cmd_we_d    = gnt1 ? req1_we_i    : req0_we_i;
    cmd_addr_d  = gnt1 ? req1_addr_i  : req0_addr_i;
    cmd_wdata_d = gnt1 ? req1_wdata_i : req0_wdata_i;
    cmd_err_d   = (cmd_addr_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_addr_q  <= 32'd0;
      cmd_wdata_q <= 32'd0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_err_q   <= cmd_err_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // Gating with rst keeps a store caught by reset from committing.
  assign mem_read_o  = cmd_valid_q && !cmd_we_q && !cmd_err_q && !rst;
  assign mem_write_o = cmd_valid_q &&  cmd_we_q && !cmd_err_q && !rst;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;

  // Response stage: one pulse per command, routed to the issuing port.
  logic [1:0]  resp_vld_q, resp_vld_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  always_comb begin
    resp_vld_d   = 2'b00;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    if (cmd_valid_q) begin
      resp_vld_d[cmd_port_q] = 1'b1;
      resp_err_d             = cmd_err_q;
      if (!cmd_we_q && !cmd_err_q) resp_rdata_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld_q   <= 2'b00;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      resp_vld_q   <= resp_vld_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp0_valid_o = resp_vld_q[0];
  assign resp1_valid_o = resp_vld_q[1];
  assign resp0_err_o   = resp_vld_q[0] && resp_err_q;
  assign resp1_err_o   = resp_vld_q[1] && resp_err_q;
  assign resp0_rdata_o = resp_vld_q[0] ? resp_rdata_q : 32'd0;
  assign resp1_rdata_o = resp_vld_q[1] ? resp_rdata_q : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 256-word memory.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        resp0_valid, resp0_err;
  logic [31:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        resp1_valid, resp1_err;
  logic [31:0] resp1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
    .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
    .resp0_valid_o(resp0_valid), .resp0_rdata_o(resp0_rdata), .resp0_err_o(resp0_err),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
    .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
    .resp1_valid_o(resp1_valid), .resp1_rdata_o(resp1_rdata), .resp1_err_o(resp1_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic do_reset();
    next_cyc(); rst = 1; idle();
    next_cyc(); rst = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"},   mem_read, 0);
    chk({tag, "_wr"},   mem_write, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wd"},   mem_wdata, 0);
    chk({tag, "_v0"},   resp0_valid, 0);
    chk({tag, "_v1"},   resp1_valid, 0);
    chk({tag, "_e0"},   resp0_err, 0);
    chk({tag, "_e1"},   resp1_err, 0);
    chk({tag, "_d0"},   resp0_rdata, 0);
    chk({tag, "_d1"},   resp1_rdata, 0);
  endtask

  initial begin
    rst = 1; idle();
    // Requests present during reset must not be accepted.
    req0_valid = 1; req1_valid = 1;
    next_cyc(); next_cyc();
    samp();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk_quiet("rst");

    // Store then load same address, port 0.
    do_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h10; req0_wdata = 32'hDEADBEEF;
    samp(); chk("t1_rdy_st", req0_ready, 1); chk("t1_wr_n", mem_write, 0);
    next_cyc(); req0_we = 0;
    samp(); chk("t1_rdy_ld", req0_ready, 1); chk("t1_wr", mem_write, 1);
    chk("t1_addr", mem_addr, 32'h10); chk("t1_wd", mem_wdata, 32'hDEADBEEF);
    chk("t1_rd_n", mem_read, 0);
    next_cyc(); req0_valid = 0;
    samp(); chk("t1_v_st", resp0_valid, 1); chk("t1_e_st", resp0_err, 0);
    chk("t1_d_st", resp0_rdata, 0); chk("t1_wr_n2", mem_write, 0); chk("t1_rd", mem_read, 1);
    next_cyc();
    samp(); chk("t1_v_ld", resp0_valid, 1); chk("t1_d_ld", resp0_rdata, 32'hDEADBEEF);
    chk("t1_v1", resp1_valid, 0); chk("t1_rd_n2", mem_read, 0);
    next_cyc();
    samp(); chk("t1_v_end", resp0_valid, 0);

    // Continuous contention: grant sequence.
    do_reset();
    req0_valid = 1; req0_addr = 32'h10;
    req1_valid = 1; req1_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      logic exp1;
`ifdef DMEM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = (i % 5) == 4;
`endif
      samp();
      chk($sformatf("t2_g1_%0d", i), req1_ready, exp1);
      chk($sformatf("t2_g0_%0d", i), req0_ready, !exp1);
      next_cyc();
    end
    idle();

    // Aliasing through address bits [9:2].
    do_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h404; req0_wdata = 32'h1;
    samp(); chk("t5_rdy", req0_ready, 1);
    next_cyc(); req0_we = 0; req0_addr = 32'h004;
    samp(); chk("t5_wr", mem_write, 1);
    next_cyc(); req0_valid = 0;
    samp(); chk("t5_v_st", resp0_valid, 1); chk("t5_d_st", resp0_rdata, 0);
    next_cyc();
    samp(); chk("t5_v_ld", resp0_valid, 1); chk("t5_d_ld", resp0_rdata, 32'h1);

    // Misaligned port 1 load; word 1 holds 1, so a leak would show.
    do_reset();
    req1_valid = 1; req1_addr = 32'h6;
    samp(); chk("t3_rdy", req1_ready, 1); chk("t3_rd0", mem_read, 0);
    next_cyc(); req1_valid = 0;
    samp(); chk("t3_rd1", mem_read, 0); chk("t3_wr1", mem_write, 0); chk("t3_v_early", resp1_valid, 0);
    next_cyc();
    samp(); chk("t3_v", resp1_valid, 1); chk("t3_e", resp1_err, 1);
    chk("t3_d", resp1_rdata, 0); chk("t3_v0", resp0_valid, 0); chk("t3_e0", resp0_err, 0);

    // Store interrupted by reset must not commit.
    do_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h20; req0_wdata = 32'h0BADF00D;
    next_cyc(); idle();
    next_cyc(); next_cyc();
    req0_valid = 1; req0_we = 1; req0_addr = 32'h20; req0_wdata = 32'h12345678;
    samp(); chk("t4_rdy", req0_ready, 1);
    next_cyc(); idle(); rst = 1;
    samp(); chk("t4_wr_rst", mem_write, 0); chk("t4_v_rst", resp0_valid, 0);
    next_cyc(); rst = 0;
    samp(); chk_quiet("t4_post"); chk("t4_mem", mem[8], 32'h0BADF00D);
    chk("t4_rdy0", req0_ready, 0); chk("t4_rdy1", req1_ready, 0);
    next_cyc();
    samp(); chk("t4_v_late", resp0_valid, 0);

    // Port 0 back-to-back with port 1 idle.
    do_reset();
    req0_valid = 1;
    for (int i = 0; i < 20; i++) begin
      req0_addr = 32'(i * 4);
      samp();
      chk($sformatf("t6_rdy0_%0d", i), req0_ready, 1);
      chk($sformatf("t6_rdy1_%0d", i), req1_ready, 0);
      if (i >= 2) chk($sformatf("t6_v_%0d", i), resp0_valid, 1);
`ifndef DMEM_ARB_RR_EN
      chk($sformatf("t6_wcnt_%0d", i), 32'(dut.wait_cnt_q), 0);
`endif
      next_cyc();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
